cache_mem_arbiter: RTL and testbench

Shares the single sram-like memory port (toward the AXI bridge) between the instruction cache and the data cache. Both caches present the same sram-like request/addr_ok/data_ok protocol that the cache miss/write-back engines already drive. The arbiter serialises their transactions, with one outstanding transaction at a time. It routes handshakes and read data back to the granted cache and keeps per-requester transaction counters for performance measurement.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/rr_grant2.sv | 37 +++
 rtl/cache_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_pkg
//  Description : Definitions shared by the I-cache, the D-cache and the
//                cache/memory arbiter: arbiter state encoding, sram-like
//                access-size encoding and the grant-bit meanings.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Arbiter transaction state. ADDR and DATA differ only in bit 1, so
  // "a transaction is in flight" is simply bit 0.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b11
  } arb_state_e;

  // sram-like access sizes
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Meaning of the grant / last_grant bits
  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage : cache_pkg
`default_nettype wire

// File: rtl/rr_grant2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant2
//  Description : Two-input tie-break for the cache/memory arbiter. Returns
//                the grant bit (GRANT_INST / GRANT_DATA) for the current
//                request pair. With ROUND_ROBIN=1 a tie goes to the side not
//                granted last; with ROUND_ROBIN=0 the data side wins ties.
//  Ports       : inst_req, data_req - pending requests
//                last_grant         - side granted by the previous transaction
//                grant              - selected side (only meaningful when at
//                                     least one request is high)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2
  import cache_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic inst_req,
  input  logic data_req,
  input  logic last_grant,
  output logic grant
);

  always_comb begin
    grant = last_grant;
    if (inst_req && !data_req) begin
      grant = GRANT_INST;
    end else if (data_req && !inst_req) begin
      grant = GRANT_DATA;
    end else if (inst_req && data_req) begin
      grant = (ROUND_ROBIN != 0) ? ~last_grant : GRANT_DATA;
    end
  end

endmodule : rr_grant2
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Shares one sram-like memory port between the I-cache and the
//                D-cache. One transaction outstanding at a time; handshakes
//                and read data are routed back to the granted cache, and a
//                completed-transaction counter is kept per requester.
//  Ports       : clk, resetn               - clock, async active-low reset
//                inst_* / data_*           - cache-side sram-like ports
//                mem_*                     - bridge-side sram-like port
//                inst_cnt, data_cnt        - completed transactions (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned ROUND_ROBIN = 1,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  // I-cache side
  input  logic                 inst_req,
  input  logic                 inst_wr,
  input  logic [1:0]           inst_size,
  input  logic [31:0]          inst_addr,
  input  logic [31:0]          inst_wdata,
  output logic [31:0]          inst_rdata,
  output logic                 inst_addr_ok,
  output logic                 inst_data_ok,
  // D-cache side
  input  logic                 data_req,
  input  logic                 data_wr,
  input  logic [1:0]           data_size,
  input  logic [31:0]          data_addr,
  input  logic [31:0]          data_wdata,
  output logic [31:0]          data_rdata,
  output logic                 data_addr_ok,
  output logic                 data_data_ok,
  // Bridge side
  output logic                 mem_req,
  output logic                 mem_wr,
  output logic [1:0]           mem_size,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_addr_ok,
  input  logic                 mem_data_ok,
  // Performance counters
  output logic [CNT_WIDTH-1:0] inst_cnt,
  output logic [CNT_WIDTH-1:0] data_cnt
);

  arb_state_e           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] inst_cnt_q, inst_cnt_d;
  logic [CNT_WIDTH-1:0] data_cnt_q, data_cnt_d;

  logic                 arb_grant;
  logic                 addr_ack;
  logic                 data_ack;
  logic                 bus_en;

  rr_grant2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_rr_grant2 (
    .inst_req   (inst_req),
    .data_req   (data_req),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= GRANT_INST;
      last_grant_q <= GRANT_INST;
      inst_cnt_q   <= '0;
      data_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      inst_cnt_q   <= inst_cnt_d;
      data_cnt_q   <= data_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    inst_cnt_d   = inst_cnt_q;
    data_cnt_d   = data_cnt_q;
    mem_req      = 1'b0;
    addr_ack     = 1'b0;
    data_ack     = 1'b0;
    bus_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          grant_d = arb_grant;
          state_d = ADDR;
        end
      end
      ADDR: begin
        mem_req = 1'b1;
        bus_en  = 1'b1;
        if (mem_addr_ok) begin
          addr_ack = 1'b1;
          // The bridge may return data in the same cycle it accepts the
          // address; the transaction then never visits DATA.
          if (mem_data_ok) begin
            data_ack = 1'b1;
            state_d  = IDLE;
          end else begin
            state_d  = DATA;
          end
        end
      end
      DATA: begin
        // Keep the mux on the granted side so the bridge sees a stable
        // address/write data until the data phase completes.
        bus_en = 1'b1;
        if (mem_data_ok) begin
          data_ack = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Every completion, including the coincident-ack case, updates the
    // round-robin history and the owning counter.
    if (data_ack) begin
      last_grant_d = grant_q;
      if (grant_q == GRANT_DATA) begin
        data_cnt_d = data_cnt_q + CNT_WIDTH'(1);
      end else begin
        inst_cnt_d = inst_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request mux toward the bridge; forced to zero while idle
  // --------------------------------------------------------------------------
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'b00;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    if (bus_en) begin
      if (grant_q == GRANT_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Acknowledge routing and read data
  // --------------------------------------------------------------------------
  assign inst_addr_ok = addr_ack && (grant_q == GRANT_INST);
  assign data_addr_ok = addr_ack && (grant_q == GRANT_DATA);
  assign inst_data_ok = data_ack && (grant_q == GRANT_INST);
  assign data_data_ok = data_ack && (grant_q == GRANT_DATA);

  // Read data is broadcast; only the matching data_ok qualifies it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign inst_cnt = inst_cnt_q;
  assign data_cnt = data_cnt_q;

endmodule : cache_mem_arbiter
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Self-checking bench for cache_mem_arbiter. Two instances
//                share all stimulus: index 1 uses ROUND_ROBIN=1, index 0 uses
//                ROUND_ROBIN=0; dsel selects which one is checked.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_mem_arbiter;

  localparam int CW = 32;

  typedef struct {
    logic        side;   // 0 = inst, 1 = data
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok, mem_data_ok;

  logic [31:0]   inst_rdata_v   [2];
  logic          inst_addr_ok_v [2];
  logic          inst_data_ok_v [2];
  logic [31:0]   data_rdata_v   [2];
  logic          data_addr_ok_v [2];
  logic          data_data_ok_v [2];
  logic          mem_req_v      [2];
  logic          mem_wr_v       [2];
  logic [1:0]    mem_size_v     [2];
  logic [31:0]   mem_addr_v     [2];
  logic [31:0]   mem_wdata_v    [2];
  logic [CW-1:0] inst_cnt_v     [2];
  logic [CW-1:0] data_cnt_v     [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cache_mem_arbiter #(
      .ROUND_ROBIN (g),
      .CNT_WIDTH   (CW)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .inst_req     (inst_req),
      .inst_wr      (inst_wr),
      .inst_size    (inst_size),
      .inst_addr    (inst_addr),
      .inst_wdata   (inst_wdata),
      .inst_rdata   (inst_rdata_v[g]),
      .inst_addr_ok (inst_addr_ok_v[g]),
      .inst_data_ok (inst_data_ok_v[g]),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_size    (data_size),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_rdata   (data_rdata_v[g]),
      .data_addr_ok (data_addr_ok_v[g]),
      .data_data_ok (data_data_ok_v[g]),
      .mem_req      (mem_req_v[g]),
      .mem_wr       (mem_wr_v[g]),
      .mem_size     (mem_size_v[g]),
      .mem_addr     (mem_addr_v[g]),
      .mem_wdata    (mem_wdata_v[g]),
      .mem_rdata    (mem_rdata),
      .mem_addr_ok  (mem_addr_ok),
      .mem_data_ok  (mem_data_ok),
      .inst_cnt     (inst_cnt_v[g]),
      .data_cnt     (data_cnt_v[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      pass_cnt  = 0;
  int      total_cnt = 0;
  int      dsel      = 1;
  logic    m_last;
  int      m_icnt, m_dcnt;
  exp_t    sb[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected grant from the arbitration rules
  function automatic logic model_grant(input logic ir, input logic dr);
    if (ir && !dr) return 1'b0;
    if (dr && !ir) return 1'b1;
    return (dsel == 1) ? ~m_last : 1'b1;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
    step();
    step();
    resetn = 1'b1;
    m_last = 1'b0;
    m_icnt = 0;
    m_dcnt = 0;
    sb.delete();
  endtask

  // One transaction. Called with the DUT in IDLE and the requests driven.
  // adly: ADDR cycles without ack; ddly: DATA cycles without ack;
  // coinc: data_ok together with addr_ok; drop: granted req falls after addr_ok.
  task automatic do_txn(input int adly, input int ddly, input logic [31:0] rd,
                        input bit coinc, input bit drop);
    logic        side;
    logic [66:0] bus_exp, bus_obs;
    logic [1:0]  aok_exp, aok_obs, dok_obs;
    exp_t        e, got;
    int          ncyc;
    bit          in_addr, a_cyc, d_cyc;
    side    = model_grant(inst_req, data_req);
    bus_exp = side ? {data_wr, data_size, data_addr, data_wdata}
                   : {inst_wr, inst_size, inst_addr, inst_wdata};
    e.side  = side;
    e.rdata = rd;
    sb.push_back(e);
    ncyc = coinc ? adly + 1 : adly + ddly + 2;
    step();  // IDLE -> ADDR
    for (int c = 0; c < ncyc; c++) begin
      in_addr = (c <= adly);
      a_cyc   = (c == adly);
      d_cyc   = coinc ? (c == adly) : (c == ncyc - 1);
      mem_addr_ok = a_cyc;
      mem_data_ok = d_cyc;
      mem_rdata   = d_cyc ? rd : 32'h0;
      @(negedge clk);
      bus_obs = {mem_wr_v[dsel], mem_size_v[dsel], mem_addr_v[dsel], mem_wdata_v[dsel]};
      total_cnt++;
      if ({mem_req_v[dsel], bus_obs} !== {in_addr, bus_exp})
        $display("FAIL bus c=%0d: got req=%b bus=%h, want req=%b bus=%h",
                 c, mem_req_v[dsel], bus_obs, in_addr, bus_exp);
      else pass_cnt++;
      aok_obs = {inst_addr_ok_v[dsel], data_addr_ok_v[dsel]};
      aok_exp = a_cyc ? (side ? 2'b01 : 2'b10) : 2'b00;
      total_cnt++;
      if (aok_obs !== aok_exp)
        $display("FAIL addr_ok c=%0d: got %b want %b", c, aok_obs, aok_exp);
      else pass_cnt++;
      dok_obs = {inst_data_ok_v[dsel], data_data_ok_v[dsel]};
      total_cnt++;
      if (d_cyc) begin
        if (dok_obs == 2'b00 || sb.size() == 0) begin
          $display("FAIL data_ok missing c=%0d: got %b", c, dok_obs);
        end else begin
          got = sb.pop_front();
          if (dok_obs !== (got.side ? 2'b01 : 2'b10) ||
              (got.side ? data_rdata_v[dsel] : inst_rdata_v[dsel]) !== got.rdata)
            $display("FAIL data_ok route: got ok=%b rdata=%h want side=%b rdata=%h",
                     dok_obs, got.side ? data_rdata_v[dsel] : inst_rdata_v[dsel],
                     got.side, got.rdata);
          else pass_cnt++;
        end
      end else if (dok_obs !== 2'b00) begin
        $display("FAIL data_ok spurious c=%0d: got %b want 00", c, dok_obs);
      end else pass_cnt++;
      step();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;
      if (drop && a_cyc) begin
        if (side) data_req = 1'b0;
        else      inst_req = 1'b0;
      end
    end
    m_last = side;
    if (side) m_dcnt++;
    else      m_icnt++;
    total_cnt++;
    if ({inst_cnt_v[dsel], data_cnt_v[dsel]} !== {CW'(m_icnt), CW'(m_dcnt)})
      $display("FAIL counters: got inst=%0d data=%0d want inst=%0d data=%0d",
               inst_cnt_v[dsel], data_cnt_v[dsel], m_icnt, m_dcnt);
    else pass_cnt++;
  endtask

  task automatic check_all_zero(input string tag);
    logic [66:0] bus_obs;
    bus_obs = {mem_wr_v[dsel], mem_size_v[dsel], mem_addr_v[dsel], mem_wdata_v[dsel]};
    total_cnt++;
    if ({mem_req_v[dsel], bus_obs} !== 68'h0)
      $display("FAIL %s bus: got req=%b bus=%h want 0", tag, mem_req_v[dsel], bus_obs);
    else pass_cnt++;
    total_cnt++;
    if ({inst_addr_ok_v[dsel], inst_data_ok_v[dsel], data_addr_ok_v[dsel],
         data_data_ok_v[dsel], inst_rdata_v[dsel], data_rdata_v[dsel]} !== 68'h0)
      $display("FAIL %s acks/rdata: got %b %b %b %b %h %h want 0", tag,
               inst_addr_ok_v[dsel], inst_data_ok_v[dsel], data_addr_ok_v[dsel],
               data_data_ok_v[dsel], inst_rdata_v[dsel], data_rdata_v[dsel]);
    else pass_cnt++;
    total_cnt++;
    if ({inst_cnt_v[dsel], data_cnt_v[dsel]} !== {CW'(0), CW'(0)})
      $display("FAIL %s counters: got %0d %0d want 0 0", tag,
               inst_cnt_v[dsel], data_cnt_v[dsel]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    dsel = 1;
    resetn = 1'b0;
    @(negedge clk);
    check_all_zero("reset_initial");
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    do_txn(0, 0, 32'h1111_2222, 0, 1);
    // Start a second transaction and abandon it mid-ADDR.
    inst_req = 1'b1; inst_addr = 32'h0000_2000;
    step();
    @(negedge clk);
    total_cnt++;
    if (mem_req_v[dsel] !== 1'b1)
      $display("FAIL reset_pre_addr: got mem_req=%b want 1", mem_req_v[dsel]);
    else pass_cnt++;
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("reset_async");
    inst_req = 1'b0;
    step();
    step();
    resetn = 1'b1;
    m_last = 1'b0; m_icnt = 0; m_dcnt = 0;
    step();
    @(negedge clk);
    check_all_zero("reset_release");
  endtask

  task automatic test_single_read();
    dsel = 1;
    do_reset();
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'b10; inst_addr = 32'hBFC0_0000;
    do_txn(2, 2, 32'h3C1D_8000, 0, 1);
    total_cnt++;
    if (inst_cnt_v[dsel] !== CW'(1))
      $display("FAIL single_read inst_cnt: got %0d want 1", inst_cnt_v[dsel]);
    else pass_cnt++;
  endtask

  task automatic test_rr1_contention();
    dsel = 1;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1000_0000;
    data_req = 1'b1; data_addr = 32'h8000_0040;
    for (int t = 0; t < 4; t++) begin
      do_txn(1, 1, 32'hA000_0000 + 32'(t), 0, 0);
      // The idle cycle between back-to-back grants
      @(negedge clk);
      total_cnt++;
      if ({mem_req_v[dsel], inst_addr_ok_v[dsel], data_addr_ok_v[dsel]} !== 3'b000)
        $display("FAIL rr1_idle_gap t=%0d: got req=%b aok=%b%b want 000", t,
                 mem_req_v[dsel], inst_addr_ok_v[dsel], data_addr_ok_v[dsel]);
      else pass_cnt++;
    end
    total_cnt++;
    if ({inst_cnt_v[dsel], data_cnt_v[dsel]} !== {CW'(2), CW'(2)})
      $display("FAIL rr1_totals: got inst=%0d data=%0d want 2 2",
               inst_cnt_v[dsel], data_cnt_v[dsel]);
    else pass_cnt++;
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  task automatic test_rr0_contention();
    dsel = 0;
    do_reset();
    inst_req = 1'b1; inst_addr = 32'h1000_0100;
    data_req = 1'b1; data_addr = 32'h8000_0200;
    for (int t = 0; t < 3; t++) do_txn(0, 1, 32'hD000_0000 + 32'(t), 0, 0);
    data_req = 1'b0;
    do_txn(0, 1, 32'hC000_0000, 0, 1);
    total_cnt++;
    if ({inst_cnt_v[dsel], data_cnt_v[dsel]} !== {CW'(1), CW'(3)})
      $display("FAIL rr0_totals: got inst=%0d data=%0d want 1 3",
               inst_cnt_v[dsel], data_cnt_v[dsel]);
    else pass_cnt++;
  endtask

  task automatic test_store();
    dsel = 1;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b00;
    data_addr = 32'h8000_1003; data_wdata = 32'h0000_00AB;
    do_txn(1, 2, 32'h0, 0, 1);
    data_wr = 1'b0; data_size = 2'b10; data_wdata = 32'h0;
  endtask

  task automatic test_back_to_back_coincident();
    dsel = 1;
    inst_req = 1'b1; inst_addr = 32'h0040_0000;
    do_txn(0, 0, 32'h2402_0001, 1, 1);
    @(negedge clk);
    total_cnt++;
    if ({mem_req_v[dsel], inst_addr_ok_v[dsel], inst_data_ok_v[dsel],
         data_addr_ok_v[dsel], data_data_ok_v[dsel]} !== 5'b00000)
      $display("FAIL coinc_after: got req=%b acks=%b%b%b%b want 00000",
               mem_req_v[dsel], inst_addr_ok_v[dsel], inst_data_ok_v[dsel],
               data_addr_ok_v[dsel], data_data_ok_v[dsel]);
    else pass_cnt++;
    data_req = 1'b1; data_addr = 32'h8000_0800;
    do_txn(2, 0, 32'h5555_AAAA, 1, 1);
    @(negedge clk);
    total_cnt++;
    if ({mem_req_v[dsel], data_addr_ok_v[dsel], data_data_ok_v[dsel]} !== 3'b000)
      $display("FAIL coinc_after_data: got req=%b acks=%b%b want 000",
               mem_req_v[dsel], data_addr_ok_v[dsel], data_data_ok_v[dsel]);
    else pass_cnt++;
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
    test_reset();
    test_single_read();
    test_store();
    test_back_to_back_coincident();
    test_rr1_contention();
    test_rr0_contention();
    total_cnt++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_cache_mem_arbiter
`default_nettype wire
